extender_pipe: RTL
==================

// Module: extender_pipe
// PURPOSE
//  Parametrised, registered immediate extender for the MIPS datapath.
//  Supports zero, sign, upper-placement (LUI) and branch-offset (sign + shift) modes.
//  Output side is a 2-entry buffer with a valid/ready handshake, so decode can stall
//  without losing immediates. Sits between instruction decode and the ALU operand mux.
// PARAMETERS
//  IN_W      16  immediate input width
//  OUT_W     32  extended output width; legal only if OUT_W >= IN_W + BR_SHIFT
//  BR_SHIFT  2   left shift applied in branch-offset mode
//  TAG_W     4   sideband tag width, carried unchanged alongside each result
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  in_valid   in   1       imm/extop/in_tag valid this cycle
//  in_ready   out  1       block can accept an input this cycle
//  imm        in   IN_W    immediate field
//  extop      in   2       00 zero, 01 sign, 10 upper, 11 branch
//  in_tag     in   TAG_W   sideband tag
//  out_valid  out  1       extout/out_tag hold a valid result
//  out_ready  in   1       consumer takes the result this cycle
//  extout     out  OUT_W   extended result
//  out_tag    out  TAG_W   tag of the result on extout
// BEHAVIOUR
//  - Arithmetic: zero = {0, imm}; sign = {{OUT_W-IN_W}{imm[IN_W-1]}, imm};
//    upper = imm << (OUT_W-IN_W), low bits 0; branch = sign result << BR_SHIFT,
//    truncated to OUT_W.
//  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Result is computed combinationally and written into a 2-entry FIFO on push.
//    Latency is 1 cycle: data pushed at edge N is on extout after edge N.
//  - Occupancy FSM: EMPTY(0) / ONE(1) / FULL(2).
//    EMPTY: push -> ONE.
//    ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop, or neither -> ONE.
//    FULL: pop -> ONE. No push is possible in FULL.
//  - in_ready = (state != FULL). It depends only on registered state and has no
//    combinational path from out_ready, so push and pop are not simultaneous in FULL.
//  - out_valid = (state != EMPTY). extout/out_tag show the head entry and stay stable
//    while out_valid & !out_ready.
//  - Pop with nothing pushed in EMPTY cannot occur (out_valid=0). Push while
//    in_ready=0 is ignored, with no state change.
//  - Read and write pointers are 1 bit each and wrap 1 -> 0.
//  - Reset (asynchronous, any cycle, including mid-transfer):
//    state=EMPTY, pointers=0, out_valid=0, in_ready=1, extout=0, out_tag=0.
//    Buffered entries are discarded. The first push after reset deassertion is
//    accepted normally.
//  - Undriven/X extop is not legal. Decode must hold extop stable while in_valid=1.
// CONFIGURATION
//  EXTENDER_LUI_EN defined:
//    extop=10 performs upper placement as above.
//  EXTENDER_LUI_EN undefined:
//    extop=10 is treated as zero-extend; no upper-placement logic is built.
//  All other modes and the handshake are identical in both builds.
// TESTING
//  1 Modes, out_ready=1:
//    imm=16'h1234 extop=00 -> 32'h00001234
//    imm=16'he001 extop=01 -> 32'hffffe001
//    imm=16'h1234 extop=01 -> 32'h00001234
//    Each appears 1 cycle after push.
//  2 Upper/branch:
//    imm=16'h1234 extop=10 -> 32'h12340000 (LUI_EN) or 32'h00001234 (no LUI_EN)
//    imm=16'hfffe extop=11 -> 32'hfffffff8
//    imm=16'h0004 extop=11 -> 32'h00000010
//  3 Backpressure: out_ready=0, push tags 1, 2, 3 on consecutive cycles.
//    -> in_ready=0 after the 2nd push; tag 3 is held off.
//    -> Raising out_ready yields tags 1, 2, 3 in order, with no loss or duplication.
//  4 Simultaneous: in ONE state, push and pop in the same cycle for 8 cycles
//    -> state stays ONE, one result/cycle, in_ready=1 throughout.
//  5 Reset mid-operation: FULL with out_ready=0, pulse reset between clock edges.
//    -> out_valid=0 and extout=0 immediately; in_ready=1.
//    -> Next push of 16'h8000 extop=01 gives 32'hffff8000.
//  6 Parameter sweep: IN_W=8, OUT_W=16, BR_SHIFT=1.
//    imm=8'h80 extop=11 -> 16'hff00
//    imm=8'h7f extop=01 -> 16'h007f

Source files
------------

// File: rtl/extender_pipe.sv
// extender_pipe: registered immediate extender for the MIPS datapath.
//
// Turns an IN_W-bit immediate into an OUT_W-bit operand using one of four
// modes (zero, sign, upper placement, branch offset). Results are queued in a
// 2-entry output buffer with a valid/ready handshake, so decode can stall
// without losing immediates. Latency from push to extout is one cycle.
//
// Build option:
//   EXTENDER_LUI_EN  defined   -> extop=10 places imm in the upper bits (LUI)
//                    undefined -> extop=10 behaves as zero-extend, and no
//                                 upper-placement logic is built
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready depends only on state)
//   imm, extop, in_tag  immediate, mode (00 zero, 01 sign, 10 upper,
//                       11 branch), sideband tag
//   out_valid/out_ready output handshake
//   extout, out_tag     head-of-buffer result and its tag
//
// OUT_W must be at least IN_W + BR_SHIFT.

// Combinational extension math, one result per call.
module extender_core #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       extop,
  output logic [OUT_W-1:0] result
);
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] bext;

  assign zext = OUT_W'(imm);
  // Sized cast of a signed operand sign-extends; also safe when OUT_W == IN_W.
  assign sext = OUT_W'($signed(imm));
  assign bext = sext << BR_SHIFT;

`ifdef EXTENDER_LUI_EN
  logic [OUT_W-1:0] uext;
  // Shift form avoids a zero-width replication when OUT_W == IN_W.
  assign uext = zext << (OUT_W - IN_W);
`endif

  always_comb begin
    result = zext;
    case (extop)
      2'b00: result = zext;
      2'b01: result = sext;
`ifdef EXTENDER_LUI_EN
      2'b10: result = uext;
`else
      2'b10: result = zext;
`endif
      2'b11: result = bext;
      default: result = zext;
    endcase
  end
endmodule

module extender_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       extop,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] extout,
  output logic [TAG_W-1:0] out_tag
);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [OUT_W-1:0] data;
  } entry_t;

  state_t           state, state_nxt;
  entry_t           mem [2];
  logic             wr_ptr, rd_ptr;
  logic             push, pop;
  logic [OUT_W-1:0] ext_res;

  extender_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .imm   (imm),
    .extop (extop),
    .result(ext_res)
  );

  // Handshake flags come straight from the registered state, so there is no
  // combinational out_ready -> in_ready path; in FULL only a pop can happen.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Storage is cleared on reset so extout/out_tag read 0 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{tag: in_tag, data: ext_res};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  // Head entry is registered, so it stays stable while stalled.
  assign extout  = mem[rd_ptr].data;
  assign out_tag = mem[rd_ptr].tag;
endmodule
